// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the IF/DM memory arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_IF   = 2'b01,
        ARB_DM   = 2'b10
    } arb_state_e;

    // DMType code for a full-word access, used for every instruction fetch.
    localparam logic [2:0] DM_WORD = 3'b000;

endpackage

// File: rtl/mem_arbiter_wdog.sv
// Wait-state watchdog: flags a transaction that has gone TIMEOUT-1 cycles without mem_ack.
module arb_wdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    input  logic ack,
    output logic expire
);

    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    logic [7:0] cnt_q, cnt_d;

    assign expire = enable && !ack && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !ack && !expire) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-ported memory between the fetch (IF) and load/store (DM) stages,
// with DM priority bounded by a starvation limit and a per-transaction watchdog.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_LIM = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    input  logic [2:0]        dm_type,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        mem_type,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              bus_err
);

    localparam int unsigned     SW  = $clog2(STARVE_LIM + 1);
    localparam logic [SW-1:0]   LIM = SW'(STARVE_LIM);

    arb_state_e        state_q, state_d;
    logic [SW-1:0]     streak_q, streak_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [2:0]        mem_type_q, mem_type_d;
    logic              expire;
    logic              waiting;

    assign waiting = (state_q != ARB_IDLE);

    // Counter is held at zero while idle, so it always starts from zero on entry to a wait state.
    arb_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (!waiting),
        .enable (waiting),
        .ack    (mem_ack),
        .expire (expire)
    );

    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_type_d  = mem_type_q;
        case (state_q)
            ARB_IDLE: begin
                if (dm_req && (!if_req || (streak_q < LIM))) begin
                    state_d     = ARB_DM;
                    mem_req_d   = 1'b1;
                    mem_we_d    = dm_we;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                    mem_type_d  = dm_type;
                    if (if_req) begin
                        streak_d = (streak_q == LIM) ? LIM : streak_q + 1'b1;
                    end else begin
                        streak_d = '0;
                    end
                end else if (if_req) begin
                    state_d     = ARB_IF;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                    mem_type_d  = DM_WORD;
                    streak_d    = '0;
                end
            end
            ARB_IF, ARB_DM: begin
                if (mem_ack || expire) begin
                    state_d   = ARB_IDLE;
                    mem_req_d = 1'b0;
                end
            end
            default: begin
                state_d   = ARB_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ARB_IDLE;
            streak_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_type_q  <= '0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_type_q  <= mem_type_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_type  = mem_type_q;

    assign if_ack   = (state_q == ARB_IF) && (mem_ack || expire);
    assign dm_ack   = (state_q == ARB_DM) && (mem_ack || expire);
    assign if_rdata = ((state_q == ARB_IF) && mem_ack) ? mem_rdata : '0;
    assign dm_rdata = ((state_q == ARB_DM) && mem_ack) ? mem_rdata : '0;
    assign bus_err  = expire;

endmodule
